// File: rtl/alu_control_mc_if.sv
// Decode-stage <-> ALU control handshake and result bus.
interface alu_control_mc_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                      opValid;
    logic                      opReady;
    logic [2:0]                aluOp;
    logic [2:0]                func;
    logic                      shiftDirection;
    logic [DATA_WIDTH-1:0]     srcA;
    logic [DATA_WIDTH-1:0]     srcB;
    logic [3:0]                aluControl;
    logic                      ctrlValid;
    logic                      illegalOp;
    logic                      busy;
    logic [2*DATA_WIDTH-1:0]   mulResult;
    logic                      mulDone;

    // Decode stage side
    modport master (
        output opValid, aluOp, func, shiftDirection, srcA, srcB,
        input  opReady, aluControl, ctrlValid, illegalOp, busy, mulResult, mulDone
    );

    // ALU control unit side
    modport slave (
        input  opValid, aluOp, func, shiftDirection, srcA, srcB,
        output opReady, aluControl, ctrlValid, illegalOp, busy, mulResult, mulDone
    );
endinterface

// File: rtl/alu_control_mc.sv
// ALU control decoder with registered outputs and a shift-add unsigned multiplier.
module alu_control_mc #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 5
) (
    input  logic               clk,
    input  logic               rst,
    alu_control_mc_if.slave    bus
);
    localparam int unsigned PW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t                 state;
    logic [PW-1:0]          mcand;
    logic [DATA_WIDTH-1:0]  mplier;
    logic [PW-1:0]          acc;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [PW-1:0]          acc_next_c;
    logic                   accept_c;

    // One shift-add step of the product
    assign acc_next_c = mplier[0] ? (acc + mcand) : acc;

    // Ready only when idle and not in reset
    assign bus.opReady = (state == IDLE) && !rst;
    assign accept_c    = bus.opValid && bus.opReady;

    // Control FSM, decode and multiplier datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.aluControl <= 4'd0;
            bus.ctrlValid  <= 1'b0;
            bus.illegalOp  <= 1'b0;
            bus.mulDone    <= 1'b0;
            bus.mulResult  <= '0;
            bus.busy       <= 1'b0;
            mcand          <= '0;
            mplier         <= '0;
            acc            <= '0;
            cnt            <= '0;
        end else begin
            bus.ctrlValid <= 1'b0;
            bus.illegalOp <= 1'b0;
            bus.mulDone   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        bus.ctrlValid <= 1'b1;
                        case (bus.aluOp)
                            3'd0: bus.aluControl <= 4'd0;
                            3'd1: bus.aluControl <= 4'd1;
                            3'd2: bus.aluControl <= {1'b0, bus.func};
                            3'd3: bus.aluControl <= bus.shiftDirection ? 4'd6 : 4'd7;
                            3'd4: bus.aluControl <= 4'd8;
                            3'd5: begin
                                // Multiply: ctrlValid is deferred to DONE
                                bus.aluControl <= 4'd9;
                                bus.ctrlValid  <= 1'b0;
                                bus.busy       <= 1'b1;
                                mcand          <= PW'(bus.srcA);
                                mplier         <= bus.srcB;
                                acc            <= '0;
                                cnt            <= '0;
                                state          <= MUL;
                            end
                            default: begin
                                bus.aluControl <= 4'd0;
                                bus.illegalOp  <= 1'b1;
                            end
                        endcase
                    end
                end
                MUL: begin
                    acc    <= acc_next_c;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_WIDTH'(1);
                    if (cnt == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                        bus.mulResult <= acc_next_c;
                        bus.mulDone   <= 1'b1;
                        bus.ctrlValid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_control_mc.sv
// Scoreboard bench for alu_control_mc: driver pushes expectations, monitor checks outputs.
module tb_alu_control_mc;
    localparam int unsigned DW = 16;

    typedef struct {
        logic [3:0]  code;
        bit          illegal;
        bit          is_mul;
        logic [31:0] prod;
        int          acc_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   vectors;
    int   miscompares;
    exp_t exp_q[$];

    alu_control_mc_if #(.DATA_WIDTH(DW)) bus ();

    alu_control_mc #(.DATA_WIDTH(DW), .CNT_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference decode table
    function automatic logic [3:0] ref_code(input logic [2:0] op, input logic [2:0] f, input logic sd);
        case (op)
            3'd0: return 4'd0;
            3'd1: return 4'd1;
            3'd2: return 4'(f);
            3'd3: return sd ? 4'd6 : 4'd7;
            3'd4: return 4'd8;
            3'd5: return 4'd9;
            default: return 4'd0;
        endcase
    endfunction

    // Present an op and hold it until accepted; returns stall count and whether busy covered every stall
    task automatic issue(input logic [2:0] op, input logic [2:0] f, input logic sd,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         output int stalls, output bit busy_ok);
        exp_t e;
        stalls  = 0;
        busy_ok = 1'b1;
        bus.opValid        = 1'b1;
        bus.aluOp          = op;
        bus.func           = f;
        bus.shiftDirection = sd;
        bus.srcA           = a;
        bus.srcB           = b;
        forever begin
            @(negedge clk);
            if (bus.opReady) break;
            stalls++;
            if (!bus.busy) busy_ok = 1'b0;
            if (stalls > 100) begin
                miscompares++;
                $display("FAIL accept_timeout: op %0d never accepted", op);
                break;
            end
        end
        if (stalls <= 100) begin
            e.code    = ref_code(op, f, sd);
            e.illegal = (op >= 3'd6);
            e.is_mul  = (op == 3'd5);
            e.prod    = 32'(a) * 32'(b);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.opValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every ctrlValid against the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ctrlValid) begin
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_ctrlValid: aluControl %0d with empty scoreboard", bus.aluControl);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("aluControl", 64'(bus.aluControl), 64'(e.code));
                    chk("illegalOp", 64'(bus.illegalOp), 64'(e.illegal));
                    chk("mulDone", 64'(bus.mulDone), 64'(e.is_mul));
                    chk("latency", 64'(cyc - e.acc_cyc), e.is_mul ? 64'(DW + 1) : 64'd1);
                    if (e.is_mul) chk("mulResult", 64'(bus.mulResult), 64'(e.prod));
                end
            end else if (bus.illegalOp || bus.mulDone) begin
                miscompares++;
                $display("FAIL stray_pulse: illegalOp %0b mulDone %0b without ctrlValid", bus.illegalOp, bus.mulDone);
            end
        end
    end

    initial begin
        int  st;
        int  st2;
        bit  bok;
        logic [2:0]    rop;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        vectors     = 0;
        miscompares = 0;
        rst                = 1'b1;
        bus.opValid        = 1'b0;
        bus.aluOp          = 3'd0;
        bus.func           = 3'd0;
        bus.shiftDirection = 1'b0;
        bus.srcA           = '0;
        bus.srcB           = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("opReady_in_reset", 64'(bus.opReady), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_aluControl", 64'(bus.aluControl), 64'd0);
        chk("rst_ctrlValid", 64'(bus.ctrlValid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_mulResult", 64'(bus.mulResult), 64'd0);
        chk("rst_opReady", 64'(bus.opReady), 64'd1);
        @(posedge clk);
        #1;

        // Back-to-back shifts, R-type, branch, illegal
        issue(3'd3, 3'd0, 1'b1, '0, '0, st, bok);
        issue(3'd3, 3'd0, 1'b0, '0, '0, st2, bok);
        chk("b2b_stalls", 64'(st + st2), 64'd0);
        issue(3'd2, 3'b101, 1'b0, '0, '0, st, bok);
        issue(3'd4, 3'd0, 1'b0, '0, '0, st, bok);
        issue(3'd6, 3'd0, 1'b0, '0, '0, st, bok);
        @(negedge clk);
        @(negedge clk);
        chk("illegal_one_cycle", 64'(bus.illegalOp), 64'd0);
        chk("ctrlValid_one_cycle", 64'(bus.ctrlValid), 64'd0);
        @(posedge clk);
        #1;

        // Max multiply with an op held from cycle 3
        issue(3'd5, 3'd0, 1'b0, 16'hFFFF, 16'hFFFF, st, bok);
        idle(2);
        issue(3'd1, 3'd0, 1'b0, '0, '0, st, bok);
        chk("held_op_stalls", 64'(st), 64'(DW + 1 - 2));
        chk("busy_while_stalled", 64'(bok), 64'd1);
        @(negedge clk);
        chk("mulResult_hold", 64'(bus.mulResult), 64'hFFFE0001);
        @(posedge clk);
        #1;

        // Reset in the middle of a multiply
        issue(3'd5, 3'd0, 1'b0, 16'd300, 16'd7, st, bok);
        idle(4);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_opReady", 64'(bus.opReady), 64'd1);
        chk("abort_mulResult", 64'(bus.mulResult), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        issue(3'd5, 3'd0, 1'b0, 16'd300, 16'd7, st, bok);

        // Randomized ops with random gaps
        for (int i = 0; i < 150; i++) begin
            idle(int'($urandom_range(0, 2)));
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: ra = '0;
                1: ra = '1;
                default: ra = DW'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = '1;
                default: rb = DW'($urandom);
            endcase
            issue(rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ra, rb, st, bok);
        end

        // Drain outstanding expectations
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
